q_server_fifo_tx: RTL and testbench

- Queue-side (requester) end of the scheduler ready/go/ena_n handshake.
- Buffers packet descriptors (lengths) in a small FIFO and raises bool_ready when the head packet fits in the current window.
- Waits for the arbiter grant (ena_n low), then holds bool_go for exactly pkt_len cycles.
- Connects directly to one bool_ready/bool_go/ena_n lane of round_robin_FP, in place of a q_server_3_states plus q_Q16 pair.

---
 rtl/q_server_fifo_tx_pkg.sv | 15 +
 rtl/q_server_fifo_tx_len_fifo.sv | 58 +++++
 rtl/q_server_fifo_tx.sv | 108 ++++++++++
 tb/tb_q_server_fifo_tx.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/q_server_fifo_tx_pkg.sv
// Shared constants for the queue-side scheduler handshake: traffic classes and FSM state encoding.
package q_server_fifo_tx_pkg;

    localparam logic [1:0] P_PCF = 2'b00;
    localparam logic [1:0] P_TT  = 2'b01;
    localparam logic [1:0] P_RC  = 2'b11;
    localparam logic [1:0] P_BE  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READY = 2'b01,
        S_GO    = 2'b10
    } state_e;

endpackage

// File: rtl/q_server_fifo_tx_len_fifo.sv
// Small synchronous FIFO of packet lengths; a pop in the same cycle frees the slot for a push when full.
module len_fifo #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned W          = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/q_server_fifo_tx.sv
// Requester end of the ready/go/ena_n handshake: queues packet lengths, requests when the head
// packet fits the class window, and holds bool_go for exactly the packet length once granted.
module q_server_fifo_tx
    import q_server_fifo_tx_pkg::*;
#(
    parameter logic [1:0]  P_CLASS    = P_TT,
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned LEN_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [LEN_W-1:0] push_len,
    output logic             full,
    output logic             overflow,
    input  logic [LEN_W-1:0] cur_value,
    input  logic             ena_n,
    output logic             bool_ready,
    output logic             bool_go,
    output logic [LEN_W-1:0] pkt_len,
    output logic             tx_done
);

    state_e           state;
    state_e           state_nxt;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_nxt;
    logic [LEN_W-1:0] head_len;
    logic             empty;
    logic             pop;
    logic             push_ok;
    logic             fits_c;
    logic             fits_q;

    assign push_ok = push && (push_len != '0);
    assign pkt_len = empty ? '0 : head_len;

    len_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .W          (LEN_W)
    ) u_len_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .pop   (pop),
        .din   (push_len),
        .dout  (head_len),
        .empty (empty),
        .full  (full)
    );

    // Best-effort traffic is not bounded by the window.
    assign fits_c = (P_CLASS == P_BE) ? !empty : (!empty && (cur_value >= head_len));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (fits_q) begin
                    state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (!fits_c) begin
                    state_nxt = S_IDLE;
                end else if (!ena_n) begin
                    state_nxt = S_GO;
                    cnt_nxt   = head_len;
                    pop       = 1'b1;
                end
            end
            S_GO: begin
                if (cnt == LEN_W'(1)) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - LEN_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            fits_q     <= 1'b0;
            overflow   <= 1'b0;
            bool_ready <= 1'b0;
            bool_go    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            fits_q     <= fits_c;
            bool_ready <= (state_nxt == S_READY);
            bool_go    <= (state_nxt == S_GO);
            tx_done    <= (state_nxt == S_GO) && (cnt_nxt == LEN_W'(1));
            if (push && ((push_len == '0) || (full && !pop))) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_q_server_fifo_tx.sv
// Scoreboard bench: stimulus queues expected packet lengths, a negedge monitor checks each go burst.
module tb_q_server_fifo_tx;

    localparam int unsigned LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             push;
    logic [LEN_W-1:0] push_len;
    logic             full;
    logic             overflow;
    logic [LEN_W-1:0] cur_value;
    logic             ena_n;
    logic             bool_ready;
    logic             bool_go;
    logic [LEN_W-1:0] pkt_len;
    logic             tx_done;

    logic             be_push;
    logic [LEN_W-1:0] be_push_len;
    logic             be_full;
    logic             be_overflow;
    logic [LEN_W-1:0] be_cur_value;
    logic             be_ena_n;
    logic             be_ready;
    logic             be_go;
    logic [LEN_W-1:0] be_pkt_len;
    logic             be_tx_done;

    always #5 clk = ~clk;

    q_server_fifo_tx #(.P_CLASS(2'b01), .DEPTH_LOG2(2), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .push(push), .push_len(push_len), .full(full),
        .overflow(overflow), .cur_value(cur_value), .ena_n(ena_n),
        .bool_ready(bool_ready), .bool_go(bool_go), .pkt_len(pkt_len), .tx_done(tx_done)
    );

    q_server_fifo_tx #(.P_CLASS(2'b10), .DEPTH_LOG2(2), .LEN_W(LEN_W)) u_be (
        .clk(clk), .rst(rst), .push(be_push), .push_len(be_push_len), .full(be_full),
        .overflow(be_overflow), .cur_value(be_cur_value), .ena_n(be_ena_n),
        .bool_ready(be_ready), .bool_go(be_go), .pkt_len(be_pkt_len), .tx_done(be_tx_done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    bit mon_en  = 1'b0;
    bit chk_gap = 1'b0;
    int pushed  = 0;
    int started = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: each go burst must match the oldest queued length and follow a valid grant.
    bit go_prev, rdy_prev, ena_prev, have_burst;
    int cur_prev, burst, cur_len, idle_run;

    always @(negedge clk) begin
        if (!mon_en) begin
            go_prev = 1'b0; rdy_prev = 1'b0; ena_prev = 1'b1; have_burst = 1'b0;
            cur_prev = 0; burst = 0; cur_len = 0; idle_run = 0;
        end else begin
            check("ready_go_exclusive", 32'(bool_ready && bool_go), 32'd0);
            if (bool_go && !go_prev) begin
                started++;
                if (exp_q.size() == 0) begin
                    check("unexpected_go", 32'd1, 32'd0);
                    cur_len = 0;
                end else begin
                    cur_len = exp_q.pop_front();
                    check("grant_after_ready", 32'(rdy_prev), 32'd1);
                    check("grant_ena_low", 32'(ena_prev), 32'd0);
                    check("grant_window_fit", 32'(cur_prev >= cur_len), 32'd1);
                    if (chk_gap && have_burst) check("gap_cycles", 32'(idle_run), 32'd2);
                end
                burst = 0;
            end
            if (bool_go) begin
                burst++;
                check("tx_done_in_burst", 32'(tx_done), 32'(burst == cur_len));
            end else begin
                check("tx_done_idle", 32'(tx_done), 32'd0);
                if (go_prev) begin
                    check("burst_len", 32'(burst), 32'(cur_len));
                    have_burst = 1'b1;
                    idle_run = 0;
                end
                idle_run++;
            end
            go_prev  = bool_go;
            rdy_prev = bool_ready;
            ena_prev = ena_n;
            cur_prev = int'(cur_value);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b1; push = 1'b0; push_len = '0; ena_n = 1'b1; cur_value = '0;
        be_push = 1'b0; be_push_len = '0; be_ena_n = 1'b1; be_cur_value = '0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        pushed = 0; started = 0; chk_gap = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic push_one(input int len, input bit expect_acc);
        push = 1'b1;
        push_len = LEN_W'(len);
        if (expect_acc) begin
            exp_q.push_back(len);
            pushed++;
        end
        tick();
        push = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int i = 0;
        while ((exp_q.size() != 0 || bool_go || bool_ready) && i < budget) begin
            tick();
            i++;
        end
        check({name, "_drain_in_time"}, 32'(i < budget), 32'd1);
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int go_cnt, done_cnt, bad, len;

        // Reset state
        do_reset();
        check("rst_ready", 32'(bool_ready), 32'd0);
        check("rst_go", 32'(bool_go), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_pkt_len", 32'(pkt_len), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);

        // BE class ignores the window and waits indefinitely for the grant
        be_cur_value = '0;
        be_push = 1'b1; be_push_len = 8'd3;
        tick();
        be_push = 1'b0;
        tick();
        tick();
        check("be_ready_latency", 32'(be_ready), 32'd1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!be_ready || be_go) bad++;
        end
        check("be_hold_ready", 32'(bad), 32'd0);
        be_ena_n = 1'b0;
        go_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (be_go) go_cnt++;
            if (be_tx_done) done_cnt++;
        end
        check("be_go_cycles", 32'(go_cnt), 32'd3);
        check("be_tx_done_count", 32'(done_cnt), 32'd1);
        be_ena_n = 1'b1;

        // TT, len 5, window 20, grant tied low
        do_reset();
        cur_value = 8'd20; ena_n = 1'b0;
        push_one(5, 1'b1);
        check("t1_pkt_len", 32'(pkt_len), 32'd5);
        tick();
        check("t1_ready_not_early", 32'(bool_ready), 32'd0);
        tick();
        check("t1_ready_at_t2", 32'(bool_ready), 32'd1);
        check("t1_go_not_early", 32'(bool_go), 32'd0);
        tick();
        check("t1_go_at_t3", 32'(bool_go), 32'd1);
        drain("t1", 20);
        check("t1_idle_pkt_len", 32'(pkt_len), 32'd0);

        // TT window too small, then grows, then shrinks while ready
        do_reset();
        cur_value = 8'd4; ena_n = 1'b1;
        push_one(8, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check("t2_no_ready_small_window", 32'(bool_ready), 32'd0);
        cur_value = 8'd8;
        tick();
        tick();
        check("t2_ready_exact_fit", 32'(bool_ready), 32'd1);
        cur_value = 8'd2;
        tick();
        check("t2_ready_withdrawn", 32'(bool_ready), 32'd0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bool_go || bool_ready) bad++;
        end
        check("t2_stays_idle", 32'(bad), 32'd0);
        cur_value = 8'd20; ena_n = 1'b0;
        drain("t2", 40);

        // Fill, overflow on full, then back-to-back bursts with one idle plus one ready cycle
        do_reset();
        cur_value = 8'd255; ena_n = 1'b1; chk_gap = 1'b1;
        push_one(2, 1'b1);
        push_one(3, 1'b1);
        push_one(4, 1'b1);
        check("t4_not_full_at_3", 32'(full), 32'd0);
        push_one(5, 1'b1);
        check("t4_full_at_4", 32'(full), 32'd1);
        check("t4_no_overflow_yet", 32'(overflow), 32'd0);
        push_one(7, 1'b0);
        check("t4_overflow_on_full", 32'(overflow), 32'd1);
        check("t4_still_full", 32'(full), 32'd1);
        check("t4_head_unchanged", 32'(pkt_len), 32'd2);
        ena_n = 1'b0;
        drain("t4", 60);
        check("t4_empty_after", 32'(pkt_len), 32'd0);

        // Push while full in the same cycle as the grant pop
        do_reset();
        cur_value = 8'd255; ena_n = 1'b1; chk_gap = 1'b1;
        push_one(3, 1'b1);
        push_one(2, 1'b1);
        push_one(2, 1'b1);
        push_one(2, 1'b1);
        tick();
        tick();
        check("t5_ready_while_full", 32'(bool_ready), 32'd1);
        check("t5_full_before", 32'(full), 32'd1);
        ena_n = 1'b0;
        push_one(9, 1'b1);
        check("t5_full_after_swap", 32'(full), 32'd1);
        check("t5_no_overflow", 32'(overflow), 32'd0);
        check("t5_go_started", 32'(bool_go), 32'd1);
        drain("t5", 60);

        // Zero length sets overflow; reset mid-transmission clears everything
        do_reset();
        cur_value = 8'd255; ena_n = 1'b0;
        push_one(0, 1'b0);
        check("t6_overflow_len0", 32'(overflow), 32'd1);
        push_one(6, 1'b1);
        bad = 0;
        while (!bool_go && bad < 10) begin
            tick();
            bad++;
        end
        check("t6_go_started", 32'(bool_go), 32'd1);
        tick();
        tick();
        mon_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("t6_rst_go", 32'(bool_go), 32'd0);
        check("t6_rst_ready", 32'(bool_ready), 32'd0);
        check("t6_rst_tx_done", 32'(tx_done), 32'd0);
        check("t6_rst_full", 32'(full), 32'd0);
        check("t6_rst_overflow", 32'(overflow), 32'd0);
        check("t6_rst_pkt_len", 32'(pkt_len), 32'd0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bool_go || tx_done || bool_ready) bad++;
        end
        check("t6_no_activity_after_rst", 32'(bad), 32'd0);

        // Randomised traffic against the queue model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            ena_n = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
            cur_value = LEN_W'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0 && (pushed - started) < 4) begin
                len = int'($urandom_range(1, 12));
                push = 1'b1;
                push_len = LEN_W'(len);
                exp_q.push_back(len);
                pushed++;
            end else begin
                push = 1'b0;
            end
            tick();
        end
        push = 1'b0;
        cur_value = 8'd255;
        ena_n = 1'b0;
        drain("rand", 200);
        check("rand_no_overflow", 32'(overflow), 32'd0);
        check("rand_all_started", 32'(started), 32'(pushed));

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
